// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the VGA sync generator (640x480 @ 60 Hz with a
// 25 MHz pixel clock), the line/frame total helper, the counter width and the
// controller state encoding.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE_DEF  = 640;
  localparam int unsigned H_FP_DEF      = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BP_DEF      = 48;
  localparam int unsigned V_ACTIVE_DEF  = 480;
  localparam int unsigned V_FP_DEF      = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BP_DEF      = 33;
  localparam int unsigned LOCK_QUAL_DEF = 16;

  // Width of the position counters and the pixel_x/pixel_y outputs.
  localparam int unsigned CNT_W = 10;

  // Total length of a line or a frame: visible + front porch + sync + back porch.
  function automatic int unsigned timing_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned H_TOTAL_DEF =
    timing_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);  // 800
  localparam int unsigned V_TOTAL_DEF =
    timing_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);  // 525

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } sync_state_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Video timing bundle produced by vga_sync_gen.
//   hsync, vsync : active-low sync pulses
//   video_on     : high inside the visible region
//   pixel_x/y    : current position
//   frame_start  : one-cycle pulse at position (0,0)
// master = timing generator (drives), slave = video consumer (reads).
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic             hsync;
  logic             vsync;
  logic             video_on;
  logic [CNT_W-1:0] pixel_x;
  logic [CNT_W-1:0] pixel_y;
  logic             frame_start;

  modport master (output hsync, vsync, video_on, pixel_x, pixel_y, frame_start);
  modport slave  (input  hsync, vsync, video_on, pixel_x, pixel_y, frame_start);
endinterface

// File: rtl/vga_lock_filter.sv
// Qualifies the clock-manager lock flag: lock_ok rises once locked has been
// sampled high on LOCK_QUAL consecutive clocks. Any low sample clears the run.
//   clk     : pixel clock
//   rst     : asynchronous, active-high reset
//   locked  : raw lock status, synchronous to clk
//   lock_ok : qualification reached (stays high while locked stays high)
module vga_lock_filter #(
  parameter int unsigned LOCK_QUAL = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic locked,
  output logic lock_ok
);

  localparam int unsigned QW = (LOCK_QUAL > 0) ? $clog2(LOCK_QUAL + 1) : 1;
  localparam logic [QW-1:0] QUAL = QW'(LOCK_QUAL);
  localparam logic [QW-1:0] ONE  = QW'(1);

  logic [QW-1:0] qual_cnt;

  // NOTE: clocked blocks use <= so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qual_cnt <= '0;
    end else if (!locked) begin
      qual_cnt <= '0;
    end else if (qual_cnt != QUAL) begin
      qual_cnt <= qual_cnt + ONE;   // saturates at QUAL
    end
  end

  assign lock_ok = (qual_cnt == QUAL);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator. Waits for a qualified clock-manager lock, then scans
// (h_cnt, v_cnt) over the full frame and derives registered sync, blanking,
// position and frame-start outputs one clock behind the counters.
//   clk    : 25 MHz pixel clock
//   RESET  : asynchronous, active-high reset
//   LOCKED : clock-manager lock status, synchronous to clk
//   vga    : timing outputs (hsync, vsync, video_on, pixel_x, pixel_y, frame_start)
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF,
  parameter int unsigned LOCK_QUAL = LOCK_QUAL_DEF
) (
  input  logic            clk,
  input  logic            RESET,
  input  logic            LOCKED,
  vga_sync_gen_if.master  vga
);

  localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_LO  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_HI  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_SYNC_LO  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_HI  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  sync_state_t      state, state_next;
  logic             lock_ok;
  logic             run_now;
  logic [CNT_W-1:0] h_cnt, v_cnt;

  vga_lock_filter #(.LOCK_QUAL(LOCK_QUAL)) u_lock_filter (
    .clk     (clk),
    .rst     (RESET),
    .locked  (LOCKED),
    .lock_ok (lock_ok)
  );

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) state <= WAIT_LOCK;
    else       state <= state_next;
  end

  // run_now is the "scanning this cycle" qualifier. Folding LOCKED into it
  // makes a lost lock blank the very next output cycle and zero the counters,
  // so an interrupted frame never leaks a partial sync pulse.
  // NOTE: defaults first so every path assigns every signal; no latch inferred.
  always_comb begin
    state_next = state;
    run_now    = 1'b0;
    case (state)
      WAIT_LOCK: if (lock_ok && LOCKED) state_next = RUN;
      RUN: begin
        if (LOCKED) run_now    = 1'b1;
        else        state_next = WAIT_LOCK;
      end
      default:      state_next = WAIT_LOCK;
    endcase
  end

  // Counters stay at (0,0) until the first RUN cycle, which therefore
  // presents (0,0); they then advance once per clock.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET || !run_now) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + ONE;
    end else begin
      h_cnt <= h_cnt + ONE;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      vga.hsync       <= 1'b1;
      vga.vsync       <= 1'b1;
      vga.video_on    <= 1'b0;
      vga.pixel_x     <= '0;
      vga.pixel_y     <= '0;
      vga.frame_start <= 1'b0;
    end else begin
      vga.hsync       <= !(run_now && h_cnt >= H_SYNC_LO && h_cnt <= H_SYNC_HI);
      vga.vsync       <= !(run_now && v_cnt >= V_SYNC_LO && v_cnt <= V_SYNC_HI);
      vga.video_on    <= run_now && (h_cnt < H_VIS) && (v_cnt < V_VIS);
      vga.pixel_x     <= run_now ? h_cnt : '0;
      vga.pixel_y     <= run_now ? v_cnt : '0;
      vga.frame_start <= run_now && (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen. Horizontal timing and lock
// qualification use the defaults; vertical timing is shortened
// (6 visible, 2 FP, 2 sync, 2 BP -> 12 lines, 9600 cycles per frame).
module tb_vga_sync_gen;

  localparam int unsigned V_ACT = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic locked = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  vga_sync_gen_if vif ();

  vga_sync_gen #(
    .V_ACTIVE (V_ACT),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (2)
  ) dut (
    .clk    (clk),
    .RESET  (reset),
    .LOCKED (locked),
    .vga    (vif.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned adv;   // clocks to advance before sampling
    logic        hs, vs, vid, fs;
    int unsigned px, py;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [23:0] pack(input logic fs, input logic vid,
                                       input logic vs, input logic hs,
                                       input int unsigned px, input int unsigned py);
    return {fs, vid, vs, hs, 10'(py), 10'(px)};
  endfunction

  function automatic logic [23:0] cur();
    return {vif.frame_start, vif.video_on, vif.vsync, vif.hsync, vif.pixel_y, vif.pixel_x};
  endfunction

  localparam logic [23:0] IDLE = {1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives LOCKED high every cycle except index 'glitch', returns the clock
  // index (0 = first edge after the call) at which frame_start is seen.
  task automatic wait_fs(input int glitch, input int limit, output int idx);
    idx = -1;
    for (int i = 0; i < limit; i++) begin
      locked = (i != glitch);
      @(posedge clk);
      #1;
      if (vif.frame_start) begin
        idx = i;
        return;
      end
    end
  endtask

  task automatic do_reset();
    locked = 1'b0;
    reset  = 1'b1;
    step(3);
    check("reset_hold", cur(), IDLE);
    reset = 1'b0;
  endtask

  initial begin
    int idx;
    int fall1, rise1, fall2;
    logic prev;
    int period, vs_low, vid_cnt, bad;

    vecs[0]  = '{0,    1'b1, 1'b1, 1'b1, 1'b1,   0,  0};
    vecs[1]  = '{639,  1'b1, 1'b1, 1'b1, 1'b0, 639,  0};
    vecs[2]  = '{1,    1'b1, 1'b1, 1'b0, 1'b0, 640,  0};
    vecs[3]  = '{16,   1'b0, 1'b1, 1'b0, 1'b0, 656,  0};
    vecs[4]  = '{95,   1'b0, 1'b1, 1'b0, 1'b0, 751,  0};
    vecs[5]  = '{1,    1'b1, 1'b1, 1'b0, 1'b0, 752,  0};
    vecs[6]  = '{47,   1'b1, 1'b1, 1'b0, 1'b0, 799,  0};
    vecs[7]  = '{1,    1'b1, 1'b1, 1'b1, 1'b0,   0,  1};
    vecs[8]  = '{4000, 1'b1, 1'b1, 1'b0, 1'b0,   0,  6};
    vecs[9]  = '{1600, 1'b1, 1'b0, 1'b0, 1'b0,   0,  8};
    vecs[10] = '{700,  1'b0, 1'b0, 1'b0, 1'b0, 700,  8};
    vecs[11] = '{899,  1'b1, 1'b0, 1'b0, 1'b0, 799,  9};
    vecs[12] = '{1,    1'b1, 1'b1, 1'b0, 1'b0,   0, 10};
    vecs[13] = '{1600, 1'b1, 1'b1, 1'b1, 1'b1,   0,  0};

    // Reset before any clock edge
    #1 reset = 1'b1;
    #2 check("reset_async_initial", cur(), IDLE);
    do_reset();

    // Idle while unlocked
    step(5);
    check("wait_lock_idle", cur(), IDLE);

    // Lock qualification: LOCKED high from cycle 0
    wait_fs(-1, 200, idx);
    check("lock_qual_latency", idx, 17);

    // 1-cycle glitch at cycle 10 delays by 11
    do_reset();
    wait_fs(10, 200, idx);
    check("lock_glitch_latency", idx, 28);

    // Line timing, starting at pixel_x=0
    fall1 = -1; rise1 = -1; fall2 = -1;
    prev = vif.hsync;
    for (int i = 1; i <= 1700; i++) begin
      step(1);
      if (prev && !vif.hsync) begin
        if (fall1 < 0) fall1 = i;
        else if (fall2 < 0) fall2 = i;
      end
      if (!prev && vif.hsync && rise1 < 0) rise1 = i;
      prev = vif.hsync;
    end
    check("hsync_fall_offset", fall1, 656);
    check("hsync_low_width", rise1 - fall1, 96);
    check("hsync_period", fall2 - fall1, 800);

    // Frame timing over one complete frame
    wait_fs(-1, 20000, idx);
    check("fs_found", (idx >= 0), 1);
    period = 0; vs_low = 0; vid_cnt = 0; bad = 0;
    do begin
      if (!vif.vsync) vs_low++;
      if (vif.video_on) begin
        vid_cnt++;
        if (vif.pixel_x >= 10'd640 || vif.pixel_y >= 10'(V_ACT)) bad++;
      end
      step(1);
      period++;
    end while (!vif.frame_start && period < 20000);
    check("frame_period", period, 9600);
    check("vsync_low_cycles", vs_low, 1600);
    check("video_on_cycles", vid_cnt, 640 * V_ACT);
    check("video_on_outside", bad, 0);

    // Table-driven positions, starting at frame_start
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].adv);
      check($sformatf("vec%0d", i), cur(),
            pack(vecs[i].fs, vecs[i].vid, vecs[i].vs, vecs[i].hs, vecs[i].px, vecs[i].py));
    end

    // Lock loss at (300,5)
    step(5 * 800 + 300);
    check("pre_loss_pos", cur(), pack(1'b0, 1'b1, 1'b1, 1'b1, 300, 5));
    locked = 1'b0;
    step(1);
    check("lock_loss_next", cur(), IDLE);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("lock_loss_hold", cur(), IDLE);
    end
    wait_fs(-1, 200, idx);
    check("relock_latency", idx, 17);
    check("relock_pos", cur(), pack(1'b1, 1'b1, 1'b1, 1'b1, 0, 0));

    // Asynchronous reset in the middle of hsync, between clock edges
    step(700);
    check("pre_reset_hsync", vif.hsync, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("async_reset", cur(), IDLE);
    step(2);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
